// File: rtl/int_controller.sv
// Interrupt controller: 16 external sources, each with a synchronizer and
// an IDLE/PEND/SERV gateway, per-source priority, enable and edge/level
// selection, a global threshold, and a claim/complete register. The highest
// priority eligible source drives a registered interrupt request.
module int_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] irq_ext,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [7:0]  bus_addr,
    input  logic        bus_wena,
    input  logic [31:0] bus_wdata,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic        irq_int_controller
);

    // Gateway state of one source.
    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_SERV = 2'd2
    } gw_state_t;

    // Word indices (byte address / 4) of the non-priority registers.
    localparam logic [5:0] IDX_PENDING   = 6'd32;
    localparam logic [5:0] IDX_ENABLE    = 6'd33;
    localparam logic [5:0] IDX_EDGE      = 6'd34;
    localparam logic [5:0] IDX_THRESHOLD = 6'd35;
    localparam logic [5:0] IDX_CLAIM     = 6'd36;

    // Synchronizer chain; s3 is the previous s2 value for edge detection.
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] s3;

    // Gateway states and configuration registers (array index i = source i+1).
    gw_state_t   gw_state [16];
    logic [2:0]  prio     [16];
    logic [15:0] enable;
    logic [15:0] edge_sel;
    logic [2:0]  threshold;

    // Derived per-source and bus decode signals.
    logic [15:0] trigger;
    logic [15:0] pending;
    logic [15:0] eligible;
    logic [4:0]  best_id;
    logic [2:0]  best_prio;
    logic [5:0]  word_idx;
    logic        xfer;
    logic        rd_xfer;
    logic        wr_xfer;
    logic        claim;
    logic        complete;
    logic [4:0]  cmpl_id;
    logic [31:0] read_value;

    // Address low bits and upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:17]};

    // The bus is ready whenever the block is out of reset, so the first access
    // after release is accepted on the first edge and reset drops it at once.
    assign bus_ready = reset;

    assign xfer     = bus_valid & bus_ready;
    assign rd_xfer  = xfer & ~bus_wena;
    assign wr_xfer  = xfer & bus_wena;
    assign word_idx = bus_addr[7:2];

    // A claim only moves state when there is something to claim.
    assign claim    = rd_xfer && (word_idx == IDX_CLAIM) && (best_id != 5'd0);
    assign complete = wr_xfer && (word_idx == IDX_CLAIM);
    assign cmpl_id  = bus_wdata[4:0];

    // Per-source trigger, pending and eligibility terms.
    always_comb begin
        // NOTE: every output of an always_comb gets a default before any
        // conditional assignment; a path that leaves one unassigned infers a latch.
        trigger  = '0;
        pending  = '0;
        eligible = '0;
        for (int i = 0; i < 16; i++) begin
            trigger[i]  = edge_sel[i] ? (s2[i] & ~s3[i]) : s2[i];
            pending[i]  = (gw_state[i] == GW_PEND);
            eligible[i] = pending[i] & enable[i] & (prio[i] > threshold);
        end
    end

    // Highest priority eligible source; the strict compare keeps the lowest ID on ties.
    always_comb begin
        best_id   = 5'd0;
        best_prio = 3'd0;
        for (int i = 0; i < 16; i++) begin
            if (eligible[i] && (prio[i] > best_prio)) begin
                best_id   = 5'(i + 1);
                best_prio = prio[i];
            end
        end
    end

    // Register read multiplexer; anything unmapped reads as zero.
    always_comb begin
        read_value = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (word_idx == 6'(i + 1)) begin
                read_value = {29'd0, prio[i]};
            end
        end
        case (word_idx)
            IDX_PENDING:   read_value = {15'd0, pending, 1'b0};
            IDX_ENABLE:    read_value = {15'd0, enable, 1'b0};
            IDX_EDGE:      read_value = {15'd0, edge_sel, 1'b0};
            IDX_THRESHOLD: read_value = {29'd0, threshold};
            IDX_CLAIM:     read_value = {27'd0, best_id};
            default:       ;
        endcase
    end

    // Two-flop synchronizer plus the edge-detect delay flop for every source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            // NOTE: non-blocking assignments let each flop take the previous
            // stage's old value; blocking ones would collapse the chain to one flop.
            s1 <= irq_ext;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the priority array is a small register file that must read
            // zero after reset, so every entry is cleared here, not left to RAM.
            for (int i = 0; i < 16; i++) begin
                prio[i] <= 3'd0;
            end
            enable    <= '0;
            edge_sel  <= '0;
            threshold <= 3'd0;
        end else if (wr_xfer) begin
            for (int i = 0; i < 16; i++) begin
                if (word_idx == 6'(i + 1)) begin
                    prio[i] <= bus_wdata[2:0];
                end
            end
            case (word_idx)
                IDX_ENABLE:    enable    <= bus_wdata[16:1];
                IDX_EDGE:      edge_sel  <= bus_wdata[16:1];
                IDX_THRESHOLD: threshold <= bus_wdata[2:0];
                default:       ;
            endcase
        end
    end

    // Gateway state machines; requests arriving in PEND or SERV are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                gw_state[i] <= GW_IDLE;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                case (gw_state[i])
                    GW_IDLE: begin
                        if (trigger[i]) begin
                            gw_state[i] <= GW_PEND;
                        end
                    end
                    GW_PEND: begin
                        if (claim && (best_id == 5'(i + 1))) begin
                            gw_state[i] <= GW_SERV;
                        end
                    end
                    GW_SERV: begin
                        // Completion always lands in IDLE; a still-active level
                        // re-pends on the following edge.
                        if (complete && (cmpl_id == 5'(i + 1))) begin
                            gw_state[i] <= GW_IDLE;
                        end
                    end
                    default: gw_state[i] <= GW_IDLE;
                endcase
            end
        end
    end

    // Registered bus response and interrupt request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_rvalid         <= 1'b0;
            bus_rdata          <= 32'd0;
            irq_int_controller <= 1'b0;
        end else begin
            bus_rvalid         <= rd_xfer;
            bus_rdata          <= rd_xfer ? read_value : 32'd0;
            irq_int_controller <= (best_id != 5'd0);
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios against fixed
// expectations plus a randomized run against a behavioural model.
module tb_int_controller;

    logic        clk;
    logic        reset;
    logic [15:0] irq_ext;
    logic        bus_valid;
    logic        bus_ready;
    logic [7:0]  bus_addr;
    logic        bus_wena;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        irq_int_controller;

    int n_checks = 0;
    int n_fail   = 0;

    int_controller dut (
        .clk                (clk),
        .reset              (reset),
        .irq_ext            (irq_ext),
        .bus_valid          (bus_valid),
        .bus_ready          (bus_ready),
        .bus_addr           (bus_addr),
        .bus_wena           (bus_wena),
        .bus_wdata          (bus_wdata),
        .bus_rvalid         (bus_rvalid),
        .bus_rdata          (bus_rdata),
        .irq_int_controller (irq_int_controller)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int S_IDLE = 0;
    localparam int S_PEND = 1;
    localparam int S_SERV = 2;

    int          m_state [1:16];
    int          m_prio  [1:16];
    logic [16:0] m_en;
    logic [16:0] m_edge;
    int          m_thr;
    // Input samples taken 1, 2 and 3 edges ago; a source sees its input two edges late.
    logic [15:0] h1, h2, h3;
    logic        m_irq;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    task automatic model_reset();
        for (int n = 1; n <= 16; n++) begin
            m_state[n] = S_IDLE;
            m_prio[n]  = 0;
        end
        m_en = '0; m_edge = '0; m_thr = 0;
        h1 = '0; h2 = '0; h3 = '0;
        m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    function automatic int m_best_id();
        int best = 0;
        int bp   = -1;
        for (int n = 1; n <= 16; n++) begin
            if (m_state[n] == S_PEND && m_en[n] && m_prio[n] > m_thr && m_prio[n] > bp) begin
                best = n;
                bp   = m_prio[n];
            end
        end
        return best;
    endfunction

    function automatic logic [31:0] m_read_reg(input logic [7:0] addr);
        int          idx = int'(addr[7:2]);
        logic [31:0] v   = '0;
        if (idx >= 1 && idx <= 16) v = 32'(m_prio[idx]);
        else if (idx == 32) begin
            for (int n = 1; n <= 16; n++) if (m_state[n] == S_PEND) v[n] = 1'b1;
        end
        else if (idx == 33) v = 32'(m_en);
        else if (idx == 34) v = 32'(m_edge);
        else if (idx == 35) v = 32'(m_thr);
        else if (idx == 36) v = 32'(m_best_id());
        return v;
    endfunction

    task automatic model_step();
        int best;
        int idx;
        int id;
        int nxt [1:16];
        best = m_best_id();
        for (int n = 1; n <= 16; n++) begin
            nxt[n] = m_state[n];
            if (m_state[n] == S_IDLE) begin
                if (m_edge[n] ? (h2[n-1] && !h3[n-1]) : h2[n-1]) nxt[n] = S_PEND;
            end
        end
        m_rvalid = 1'b0;
        m_rdata  = '0;
        if (bus_valid) begin
            idx = int'(bus_addr[7:2]);
            if (!bus_wena) begin
                m_rvalid = 1'b1;
                m_rdata  = m_read_reg(bus_addr);
                if (idx == 36 && best != 0) nxt[best] = S_SERV;
            end else begin
                if (idx >= 1 && idx <= 16) m_prio[idx] = int'(bus_wdata[2:0]);
                else if (idx == 33) m_en = {bus_wdata[16:1], 1'b0};
                else if (idx == 34) m_edge = {bus_wdata[16:1], 1'b0};
                else if (idx == 35) m_thr = int'(bus_wdata[2:0]);
                else if (idx == 36) begin
                    id = int'(bus_wdata[4:0]);
                    if (id >= 1 && id <= 16 && m_state[id] == S_SERV) nxt[id] = S_IDLE;
                end
            end
        end
        for (int n = 1; n <= 16; n++) m_state[n] = nxt[n];
        m_irq = (best != 0);
        h3 = h2; h2 = h1; h1 = irq_ext;
    endtask

    // ---------------- bus helpers ----------------
    // One clock edge; inputs are changed only at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data, output logic rv);
        bus_valid = 1'b1; bus_wena = 1'b0; bus_addr = addr; bus_wdata = '0;
        tick();
        data = bus_rdata;
        rv   = bus_rvalid;
        bus_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        bus_valid = 1'b1; bus_wena = 1'b1; bus_addr = addr; bus_wdata = data;
        tick();
        bus_valid = 1'b0; bus_wena = 1'b0;
    endtask

    task automatic do_reset();
        irq_ext = '0;
        bus_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic        rv;
        n_checks++;
        if ({irq_int_controller, bus_ready, bus_rvalid} !== 3'b000 || bus_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b ready=%b rvalid=%b rdata=%h, expected all 0",
                     irq_int_controller, bus_ready, bus_rvalid, bus_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: bus_ready=%b expected 1", bus_ready);
        end
        bus_read(8'h84, rd, rv);
        n_checks++;
        if (rv !== 1'b1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_first_access: rvalid=%b rdata=%h expected 1/0", rv, rd);
        end
        bus_read(8'h04, rd, rv);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_prio: got %h expected 0", rd);
        end
        tick();
        n_checks++;
        if (bus_rvalid !== 1'b0 || bus_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rvalid_one_cycle: rvalid=%b rdata=%h expected 0/0", bus_rvalid, bus_rdata);
        end
    endtask

    task automatic test_level_flow();
        logic [31:0] rd;
        logic        rv;
        do_reset();
        bus_write(8'h0C, 32'd5);
        bus_write(8'h84, 32'h8);
        irq_ext[2] = 1'b1;
        tick(); tick();
        n_checks++;
        if (irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL level_irq_early: irq=%b expected 0", irq_int_controller);
        end
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h0 || irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL level_pending_k2: pending=%h irq=%b expected 0/0", rd, irq_int_controller);
        end
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h8 || irq_int_controller !== 1'b1) begin
            n_fail++;
            $display("FAIL level_pending_k3: pending=%h irq=%b expected 8/1", rd, irq_int_controller);
        end
        bus_read(8'h90, rd, rv);
        n_checks++;
        if (rd !== 32'd3) begin
            n_fail++;
            $display("FAIL level_claim: got %0d expected 3", rd);
        end
        tick();
        n_checks++;
        if (irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL level_irq_drop: irq=%b expected 0", irq_int_controller);
        end
        bus_write(8'h90, 32'd3);
        tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h8 || irq_int_controller !== 1'b1) begin
            n_fail++;
            $display("FAIL level_repend: pending=%h irq=%b expected 8/1", rd, irq_int_controller);
        end
    endtask

    task automatic test_tie_break();
        logic [31:0] rd;
        logic        rv;
        do_reset();
        bus_write(8'h08, 32'd4);
        bus_write(8'h14, 32'd4);
        bus_write(8'h84, 32'h24);
        irq_ext = 16'h0012;
        repeat (4) tick();
        bus_read(8'h90, rd, rv);
        n_checks++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL tie_claim1: got %0d expected 2", rd);
        end
        bus_read(8'h90, rd, rv);
        n_checks++;
        if (rd !== 32'd5) begin
            n_fail++;
            $display("FAIL tie_claim2: got %0d expected 5", rd);
        end
        bus_read(8'h90, rd, rv);
        n_checks++;
        if (rd !== 32'd0 || irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_claim3: got %0d irq=%b expected 0/0", rd, irq_int_controller);
        end
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL tie_no_change: pending=%h expected 0", rd);
        end
    endtask

    task automatic test_threshold();
        logic [31:0] rd;
        logic        rv;
        do_reset();
        bus_write(8'h1C, 32'd2);
        bus_write(8'h84, 32'h80);
        bus_write(8'h8C, 32'd2);
        irq_ext[6] = 1'b1;
        repeat (5) tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h80 || irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_blocked: pending=%h irq=%b expected 80/0", rd, irq_int_controller);
        end
        bus_write(8'h8C, 32'd1);
        n_checks++;
        if (irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_irq_same_cycle: irq=%b expected 0", irq_int_controller);
        end
        tick();
        n_checks++;
        if (irq_int_controller !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_irq_after: irq=%b expected 1", irq_int_controller);
        end
        bus_write(8'h84, 32'h0);
        tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h80 || irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_keeps_pending: pending=%h irq=%b expected 80/0", rd, irq_int_controller);
        end
    endtask

    task automatic test_edge_mode();
        logic [31:0] rd;
        logic        rv;
        do_reset();
        bus_write(8'h04, 32'd1);
        bus_write(8'h84, 32'h2);
        bus_write(8'h88, 32'h2);
        irq_ext[0] = 1'b1;
        tick(); tick();
        irq_ext[0] = 1'b0;
        repeat (4) tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h2 || irq_int_controller !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_latched: pending=%h irq=%b expected 2/1", rd, irq_int_controller);
        end
        bus_read(8'h90, rd, rv);
        n_checks++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL edge_claim: got %0d expected 1", rd);
        end
        repeat (2) begin
            irq_ext[0] = 1'b1;
            tick(); tick();
            irq_ext[0] = 1'b0;
            repeat (3) tick();
        end
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL edge_drop_in_serv: pending=%h expected 0", rd);
        end
        bus_write(8'h90, 32'd1);
        repeat (3) tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h0 || irq_int_controller !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_after_complete: pending=%h irq=%b expected 0/0", rd, irq_int_controller);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] rd;
        logic        rv;
        do_reset();
        bus_write(8'h0C, 32'd5);
        bus_write(8'h84, 32'h8);
        irq_ext[2] = 1'b1;
        repeat (5) tick();
        bus_read(8'h90, rd, rv);
        bus_write(8'h90, 32'd17);
        bus_write(8'h80, 32'hFFFF_FFFF);
        repeat (3) tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL bad_id_ignored: pending=%h expected 0", rd);
        end
        bus_read(8'hFC, rd, rv);
        n_checks++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: rvalid=%b rdata=%h expected 1/0", rv, rd);
        end
        bus_write(8'h04, 32'hFFFF_FFFF);
        bus_read(8'h07, rd, rv);
        n_checks++;
        if (rd !== 32'd7) begin
            n_fail++;
            $display("FAIL prio_width: got %h expected 7", rd);
        end
        bus_write(8'h90, 32'd3);
        tick();
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rd !== 32'h8) begin
            n_fail++;
            $display("FAIL complete_repend: pending=%h expected 8", rd);
        end
        // Reset mid-cycle while a response and the interrupt are both active.
        bus_read(8'h80, rd, rv);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({irq_int_controller, bus_ready, bus_rvalid} !== 3'b000 || bus_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: irq=%b ready=%b rvalid=%b rdata=%h expected all 0",
                     irq_int_controller, bus_ready, bus_rvalid, bus_rdata);
        end
        irq_ext = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(8'h80, rd, rv);
        n_checks++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: rvalid=%b pending=%h expected 1/0", rv, rd);
        end
    endtask

    task automatic test_random();
        int op;
        int id;
        int off;
        int nn;
        do_reset();
        for (int n = 1; n <= 16; n++) bus_write(8'(4 * n), 32'($urandom_range(0, 7)));
        bus_write(8'h84, $urandom);
        bus_write(8'h88, $urandom);
        bus_write(8'h8C, 32'($urandom_range(0, 3)));
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 2) == 0) irq_ext[$urandom_range(0, 15)] ^= 1'b1;
            op = int'($urandom_range(0, 99));
            bus_valid = 1'b0; bus_wena = 1'b0; bus_addr = '0; bus_wdata = '0;
            if (op >= 35 && op < 55) begin
                bus_valid = 1'b1; bus_addr = 8'h90;
            end else if (op >= 55 && op < 72) begin
                id = int'($urandom_range(0, 20));
                if ($urandom_range(0, 3) != 0) begin
                    off = int'($urandom_range(0, 15));
                    for (int j = 0; j < 16; j++) begin
                        nn = ((off + j) % 16) + 1;
                        if (m_state[nn] == S_SERV) begin
                            id = nn;
                            break;
                        end
                    end
                end
                bus_valid = 1'b1; bus_wena = 1'b1; bus_addr = 8'h90;
                bus_wdata = {$urandom_range(0, 7), 24'd0, 8'(id)} & 32'hE000_00FF;
            end else if (op >= 72 && op < 90) begin
                bus_valid = 1'b1; bus_addr = 8'($urandom);
            end else if (op >= 90) begin
                bus_valid = 1'b1; bus_wena = 1'b1; bus_addr = 8'($urandom); bus_wdata = $urandom;
            end
            tick();
            bus_valid = 1'b0;
            n_checks++;
            if (bus_rvalid !== m_rvalid || bus_rdata !== m_rdata || irq_int_controller !== m_irq) begin
                n_fail++;
                $display("FAIL random_cycle %0d: rvalid=%b rdata=%h irq=%b expected %b %h %b",
                         c, bus_rvalid, bus_rdata, irq_int_controller, m_rvalid, m_rdata, m_irq);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        irq_ext   = '0;
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_wena  = 1'b0;
        bus_wdata = '0;
        model_reset();
        #2;
        test_reset();
        test_level_flow();
        test_tie_break();
        test_threshold();
        test_edge_mode();
        test_boundaries();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; all sequential logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-003 SHALL have ports: irq_ext  in  16  asynchronous external sources; bit i is source ID i+1.
REQ-004 SHALL have ports: bus_valid  in  1  register access request.
REQ-005 SHALL have ports: bus_ready  out  1  request accepted.
REQ-006 SHALL have ports: bus_addr  in  8  byte address, word aligned; bits 1:0 ignored.
REQ-007 SHALL have ports: bus_wena  in  1  1=write, 0=read.
REQ-008 SHALL have ports: bus_wdata  in  32  write data.
REQ-009 SHALL have ports: bus_rvalid  out  1  read data valid.
REQ-010 SHALL have ports: bus_rdata  out  32  read data.
REQ-011 SHALL have ports: irq_int_controller  out  1  interrupt request to the CSR file (MEIP-class).

Function
REQ-012 SHALL provide this register map:
- 0x04+4*(n-1): priority[n], 3 bits, n=1..16.
- 0x80: pending, bits 16:1, read-only.
- 0x84: enable, bits 16:1.
- 0x88: edge select, bits 16:1; 1=edge, 0=level.
- 0x8C: threshold, 3 bits.
- 0x90: claim/complete.
REQ-013 Reads of unmapped addresses SHALL return 0; writes to unmapped or read-only locations SHALL be ignored; unimplemented bits SHALL read 0.
REQ-014 A transfer SHALL occur when bus_valid and bus_ready are both 1; bus_ready SHALL be 1 whenever reset=1.
REQ-015 For an accepted read, bus_rvalid SHALL be 1 for exactly the next cycle, with bus_rdata registered; otherwise bus_rdata=0.
REQ-016 Each irq_ext bit SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3 used for edge detection.
REQ-017 Gateway: a source SHALL be in one of three states, IDLE, PEND or SERV.
- IDLE->PEND: level mode with s2=1, or edge mode with s2=1 and s3=0.
- PEND->SERV: the source is claimed.
- SERV->IDLE: a complete is written for that ID.
REQ-018 Edges or levels arriving in PEND or SERV SHALL be dropped.
REQ-019 A level source still asserted after completion SHALL re-enter PEND on the next edge.
REQ-020 Pending bit n SHALL equal (state[n]==PEND).
REQ-021 A source SHALL be eligible when all hold: state PEND, enable=1, priority>threshold. Priority 0 is therefore never eligible.
REQ-022 best_id SHALL be the eligible ID with the highest priority; ties SHALL go to the lowest ID; best_id=0 when nothing is eligible.
REQ-023 irq_int_controller SHALL be a register loaded each cycle with (best_id!=0).
REQ-024 Latency SHALL be: irq_ext high sampled at edge k -> pending at edge k+2 -> irq_int_controller=1 after edge k+3.
REQ-025 A read of 0x90 SHALL return best_id and, on the same edge, move that source PEND->SERV; if best_id=0, the read returns 0 and changes no state.
REQ-026 A write of 0x90 SHALL complete source wdata[4:0] if it is in SERV; IDs outside 1..16, or sources not in SERV, SHALL be ignored.
REQ-027 When a claim coincides with a new edge on the same source, the claim SHALL win and the edge SHALL be dropped.
REQ-028 When a complete coincides with an active level on the same source, the state SHALL go to IDLE, and then to PEND on the following edge.
REQ-029 Register writes to priority, enable or threshold SHALL affect eligibility from the next cycle.
REQ-030 Disabling a PEND source SHALL keep it pending without asserting the interrupt.

Reset
REQ-031 While reset=0, the following SHALL hold asynchronously:
- All synchronizer flops = 0.
- All gateway states = IDLE.
- Priority, enable, edge select and threshold registers = 0.
- irq_int_controller = 0, bus_ready = 0, bus_rvalid = 0, bus_rdata = 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no response.
REQ-033 After reset=1, the first access SHALL be accepted on the first edge.

Verification
REQ-034 Setup prio[3]=5, enable bit3, threshold 0, level mode; raise irq_ext[2] -> pending=0x8 at k+2, irq_int_controller=1 after k+3; read 0x90 returns 3; irq drops next cycle; write 3 to 0x90 with line still high -> pending again 2 cycles later.
REQ-035 Tie-break: sources 2 and 5 both at prio 4 -> claim returns 2, then 5; a third claim returns 0 with no state change.
REQ-036 Threshold: prio[7]=2, threshold=2 -> no irq; set threshold=1 -> irq=1 two cycles later.
REQ-037 Edge mode: pulse irq_ext[0] twice while in SERV -> second pulse dropped; after complete, pending=0.
REQ-038 Boundaries: complete with wrong ID 17 -> ignored; read at 0xFC -> 0; reset asserted while PEND -> all outputs 0 immediately, pending=0 after release.
